// File: rtl/full_st1_phase_sequencer.sv
// Training-step phase sequencer for one stage-1 data-FIFO controller: FWD, ERR_FIRST, ERR, DRAIN.
// Optional status outputs (step counter, protocol-error flag) are enabled with FULL_ST1_SEQ_STATUS_EN.
module full_st1_phase_sequencer #(
    parameter int DEPTH_W      = 3,
    parameter int LEN_W        = 4,
    parameter int CNT_W        = 4,
    parameter int DRAIN_CYCLES = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [DEPTH_W-1:0] cfg_depth,
    input  logic [LEN_W-1:0]   cfg_length,
    input  logic [CNT_W-1:0]   cfg_fwd_states,
    input  logic [CNT_W-1:0]   cfg_err_states,
    input  logic               start,
    input  logic               stop,
    input  logic               read_finish,
    input  logic               err_finish_i,
    output logic [DEPTH_W-1:0] load_depth,
    output logic [LEN_W-1:0]   load_length,
    output logic               error_update_mode,
    output logic               error_update_latch,
    output logic               error_update_first,
    output logic               error_tap_update_out,
    output logic               error_finish_tap,
    output logic               busy,
    output logic [2:0]         phase,
    output logic               done
`ifdef FULL_ST1_SEQ_STATUS_EN
    ,
    output logic [15:0]        status_steps,
    output logic               status_proto_err
`endif
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FWD       = 3'd1,
        ERR_FIRST = 3'd2,
        ERR       = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
    logic [DRAIN_W-1:0] drain_cnt, drain_next;
    logic               done_next;
    logic [CNT_W-1:0]   fwd_states, err_states;
    logic [CNT_W-1:0]   fwd_last, err_last;
    logic               err_phase;

    assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign fwd_last  = (fwd_states == '0) ? '0 : fwd_states - CNT_W'(1);
    assign err_last  = err_states - CNT_W'(1);
    assign err_phase = (state == ERR_FIRST) || (state == ERR);

    assign phase                = state;
    assign busy                 = (state != IDLE);
    assign error_update_mode    = err_phase;
    assign error_update_latch   = err_phase;
    assign error_update_first   = (state == ERR_FIRST);
    assign error_tap_update_out = err_phase && (cnt != err_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            drain_cnt        <= '0;
            done             <= 1'b0;
            error_finish_tap <= 1'b0;
            load_depth       <= '0;
            load_length      <= '0;
            fwd_states       <= '0;
            err_states       <= '0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            drain_cnt        <= drain_next;
            done             <= done_next;
            error_finish_tap <= err_finish_i && err_phase;
            if (cfg_wr && state == IDLE) begin
                load_depth  <= cfg_depth;
                load_length <= cfg_length;
                fwd_states  <= cfg_fwd_states;
                err_states  <= cfg_err_states;
            end
        end
    end

    // Next-state logic; stop outranks a coincident read_finish in every active phase.
    // ERR is entered with cnt = 1 because the ERR_FIRST state already was error state 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        drain_next = drain_cnt;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FWD;
                    cnt_next   = '0;
                end
            end
            FWD: begin
                if (stop) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                    drain_next = DRAIN_LOAD;
                end else if (read_finish) begin
                    if (cnt == fwd_last) begin
                        cnt_next = '0;
                        if (err_states != '0) begin
                            state_next = ERR_FIRST;
                        end else begin
                            state_next = DRAIN;
                            drain_next = DRAIN_LOAD;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            ERR_FIRST: begin
                if (stop) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                    drain_next = DRAIN_LOAD;
                end else if (read_finish) begin
                    if (err_states > CNT_W'(1)) begin
                        state_next = ERR;
                        cnt_next   = CNT_W'(1);
                    end else begin
                        state_next = DRAIN;
                        cnt_next   = '0;
                        drain_next = DRAIN_LOAD;
                    end
                end
            end
            ERR: begin
                if (stop || (read_finish && cnt == err_last)) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                    drain_next = DRAIN_LOAD;
                end else if (read_finish) begin
                    cnt_next = cnt_inc;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    drain_next = drain_cnt - DRAIN_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                drain_next = '0;
            end
        endcase
    end

`ifdef FULL_ST1_SEQ_STATUS_EN
    // Completed-step counter wraps freely; protocol error is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_steps     <= '0;
            status_proto_err <= 1'b0;
        end else begin
            if (done_next) status_steps <= status_steps + 16'd1;
            if (state == IDLE && (read_finish || err_finish_i)) status_proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_full_st1_phase_sequencer.sv
// Directed self-checking bench for full_st1_phase_sequencer; expected values are hand-computed.
// Status-port checks are included when FULL_ST1_SEQ_STATUS_EN is defined.
module tb_full_st1_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_depth = '0;
    logic [3:0] cfg_length = '0;
    logic [3:0] cfg_fwd_states = '0;
    logic [3:0] cfg_err_states = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       read_finish = 1'b0;
    logic       err_finish_i = 1'b0;
    logic [2:0] load_depth;
    logic [3:0] load_length;
    logic       error_update_mode, error_update_latch, error_update_first;
    logic       error_tap_update_out, error_finish_tap, busy, done;
    logic [2:0] phase;
`ifdef FULL_ST1_SEQ_STATUS_EN
    logic [15:0] status_steps;
    logic        status_proto_err;
`endif

    int checks = 0;
    int failures = 0;

    full_st1_phase_sequencer dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_depth(cfg_depth), .cfg_length(cfg_length),
        .cfg_fwd_states(cfg_fwd_states), .cfg_err_states(cfg_err_states), .start(start), .stop(stop),
        .read_finish(read_finish), .err_finish_i(err_finish_i), .load_depth(load_depth),
        .load_length(load_length), .error_update_mode(error_update_mode),
        .error_update_latch(error_update_latch), .error_update_first(error_update_first),
        .error_tap_update_out(error_tap_update_out), .error_finish_tap(error_finish_tap),
        .busy(busy), .phase(phase), .done(done)
`ifdef FULL_ST1_SEQ_STATUS_EN
        , .status_steps(status_steps), .status_proto_err(status_proto_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of control pulses, then all pulses cleared; returns #1 after the edge.
    task automatic applyStimulus(input logic rf, input logic ef, input logic st, input logic sp);
        read_finish  = rf;
        err_finish_i = ef;
        start        = st;
        stop         = sp;
        step();
        read_finish  = 1'b0;
        err_finish_i = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
    endtask

    task automatic writeCfg(input logic [2:0] d, input logic [3:0] l, input logic [3:0] f,
                            input logic [3:0] e, input logic with_start);
        cfg_depth      = d;
        cfg_length     = l;
        cfg_fwd_states = f;
        cfg_err_states = e;
        cfg_wr         = 1'b1;
        start          = with_start;
        step();
        cfg_wr = 1'b0;
        start  = 1'b0;
    endtask

    // Counts DRAIN cycles (n_start already observed), expects 18 in total, then a one-cycle done.
    task automatic checkDrain(input string tag, input int n_start);
        int n = n_start;
        while (phase == 3'd4 && n < 40) begin
            step();
            if (phase == 3'd4) n++;
        end
        checkOutput({tag, "_drain_len"}, n, 18);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_idle"}, phase, 0);
        step();
        checkOutput({tag, "_done_clr"}, done, 0);
    endtask

    initial begin
        // T1: reset with random inputs
        cfg_wr = 1'($urandom); cfg_depth = 3'($urandom); cfg_length = 4'($urandom);
        cfg_fwd_states = 4'($urandom); cfg_err_states = 4'($urandom);
        start = 1'($urandom); stop = 1'($urandom);
        read_finish = 1'($urandom); err_finish_i = 1'($urandom);
        step(); step();
        checkOutput("rst_phase", phase, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_depth", load_depth, 0);
        checkOutput("rst_length", load_length, 0);
        checkOutput("rst_err_outs", {error_update_mode, error_update_latch, error_update_first,
                                     error_tap_update_out, error_finish_tap, done}, 0);
        cfg_wr = 0; start = 0; stop = 0; read_finish = 0; err_finish_i = 0;
        reset = 1'b1;
        step(); step(); step();
        checkOutput("idle_hold", phase, 0);

        // T2: nominal step depth=3 len=9 fwd=2 err=3
        writeCfg(3'd3, 4'd9, 4'd2, 4'd3, 1'b0);
        checkOutput("t2_depth", load_depth, 3);
        checkOutput("t2_length", load_length, 9);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t2_fwd", phase, 1);
        checkOutput("t2_busy", busy, 1);
        step();
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_fwd_after_rf1", phase, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_err_first", phase, 2);
        checkOutput("t2_first_outs", {error_update_mode, error_update_latch, error_update_first,
                                      error_tap_update_out}, 4'b1111);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_err", phase, 3);
        checkOutput("t2_err_outs", {error_update_mode, error_update_latch, error_update_first,
                                    error_tap_update_out}, 4'b1101);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_err_last", phase, 3);
        checkOutput("t2_tap_last", error_tap_update_out, 0);
        checkOutput("t2_mode_last", error_update_mode, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_drain", phase, 4);
        checkOutput("t2_drain_outs", {error_update_mode, error_update_latch, error_update_first,
                                      error_tap_update_out}, 0);
        checkDrain("t2", 1);

        // T3: fwd=0 err=0 goes straight to DRAIN
        writeCfg(3'd1, 4'd2, 4'd0, 4'd0, 1'b0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t3_fwd", phase, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t3_drain", phase, 4);
        checkOutput("t3_mode", error_update_mode, 0);
        checkDrain("t3", 1);

        // T4: stop coincident with read_finish in ERR, then stop again in DRAIN
        writeCfg(3'd2, 4'd4, 4'd1, 4'd3, 1'b0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t4_err_first", phase, 2);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t4_err", phase, 3);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t4_abort", phase, 4);
        checkOutput("t4_abort_outs", {error_update_mode, error_update_latch, error_update_first,
                                      error_tap_update_out, error_finish_tap}, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_stop_in_drain", phase, 4);
        checkDrain("t4", 2);

        // T5: cfg_wr ignored while busy; cfg_wr+start together uses the new values
        writeCfg(3'd2, 4'd5, 4'd1, 4'd0, 1'b0);
        applyStimulus(0, 0, 1, 0);
        writeCfg(3'd7, 4'd12, 4'd3, 4'd3, 1'b0);
        checkOutput("t5_len_guard", load_length, 5);
        checkOutput("t5_depth_guard", load_depth, 2);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t5_drain", phase, 4);
        checkDrain("t5a", 1);
        writeCfg(3'd6, 4'd7, 4'd1, 4'd0, 1'b1);
        checkOutput("t5_wr_start_phase", phase, 1);
        checkOutput("t5_wr_start_depth", load_depth, 6);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t5_stop_fwd", phase, 4);
        checkDrain("t5b", 1);

        // T6: error_finish_tap only from err_finish_i in ERR phases
        writeCfg(3'd3, 4'd9, 4'd1, 4'd3, 1'b0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t6_tap_fwd", error_finish_tap, 0);
        step();
        checkOutput("t6_tap_fwd_late", error_finish_tap, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t6_err", phase, 3);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t6_tap_pulse", error_finish_tap, 1);
        step();
        checkOutput("t6_tap_width", error_finish_tap, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t6_drain", phase, 4);
        checkDrain("t6", 1);
`ifdef FULL_ST1_SEQ_STATUS_EN
        checkOutput("st_steps", status_steps, 6);
        checkOutput("st_proto_clear", status_proto_err, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("st_proto_set", status_proto_err, 1);
        step();
        checkOutput("st_proto_sticky", status_proto_err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
